pipe_rr_arbiter: RTL and testbench
==================================

# pipe_rr_arbiter

Round-robin arbiter that shares one downstream `PipeIn` sink between `N` upstream enq requesters. It sits in front of a single-consumer pipe, such as a mux/forwarding stage or a FIFO input, where several producers must be serialized. Each requester gets a 1-entry holding register. A rotating-priority scheduler drains those registers into the output one beat per cycle, and tags each beat with its source index.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `WIDTH`, default 144: payload width in bits.
- `IDXW`, default 2: index width; must equal ceil(log2 N).

Ports:
- `CLK`  in  1: single clock; all state updates on rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `in_enq__ENA`  in  N: per-requester enq strobe; bit i is valid only while `in_enq__RDY[i]` = 1.
- `in_enq_v`  in  N*WIDTH: per-requester payload; requester i occupies bits [i*WIDTH +: WIDTH].
- `in_enq__RDY`  out  N: requester i may enq this cycle.
- `prio_fixed`  in  1: 0 = round-robin, 1 = fixed priority (lowest index wins); sampled every cycle.
- `out_enq__ENA`  out  1: beat presented to the sink this cycle.
- `out_enq_v`  out  WIDTH: beat payload.
- `out_src`  out  IDXW: requester index of the current beat.
- `out_enq__RDY`  in  1: sink can accept a beat.

## Operation
State:
- `full[N]`
- `data[N][WIDTH]`
- `last` (IDXW): index of the most recent winner.

Reset (RST = 1 at a clock edge):
- `full` ← 0, `last` ← N-1, so requester 0 has top round-robin priority after reset.
- Buffered data is discarded. No output beat is produced in a cycle where RST is high.

Outputs while RST is high and on the cycle after reset:
- `in_enq__RDY` = 0 while RST is high.
- `out_enq__ENA` = 0.
- `out_enq_v` = 0.
- `out_src` = 0.

Capture:
- `in_enq__RDY[i]` = !full[i] && !RST. It is registered-only and has no combinational path from `out_enq__RDY`.
- On an edge with `in_enq__ENA[i]` && `in_enq__RDY[i]`: `full[i]` ← 1 and `data[i]` ← slice i of `in_enq_v`.
- An ENA without RDY is a protocol violation. It is ignored, with no state change.

Arbitration (combinational each cycle):
- Candidates are the `full` bits.
- prio_fixed = 0: the winner is the first full index scanning last+1, last+2, … modulo N.
- prio_fixed = 1: the winner is the lowest full index.
- `out_enq__ENA` = (any full) && `out_enq__RDY`. ENA is never asserted without RDY.
- When ENA = 1: `out_enq_v` = data[winner] and `out_src` = winner. Otherwise both are 0.

Drain (edge with `out_enq__ENA` = 1):
- `full[winner]` ← 0.
- `last` ← winner, updated in both modes so round-robin resumes fairly.

Simultaneous events:
- A requester cannot enq into its slot on the same edge the slot drains, because RDY was 0 that cycle.
- Per-requester throughput is at most 1 beat per 2 cycles.
- Aggregate throughput is 1 beat/cycle whenever ≥2 slots are full.
- `prio_fixed` toggling mid-stream takes effect in the same cycle. No beat is lost or duplicated.
- Reset mid-operation drops all pending beats. The sink sees no partial or extra beat.

Fairness:
- In round-robin mode with all N slots continuously refilled, each requester wins exactly once every N beats.
- Fixed mode may starve high indices; this is intended.

## Timing
- Minimum latency from requester enq edge to `out_enq__ENA`: 1 cycle. The beat is visible the cycle after capture if the sink is ready and the requester wins.
- `in_enq__RDY[i]` rises the cycle after the drain edge of slot i.
- `out_enq_v`, `out_src` and `out_enq__ENA` depend combinationally on registered state, `prio_fixed` and `out_enq__RDY`. There is no path from `in_enq__*` to any output.
- While `out_enq__RDY` is held low, slots stay full, `last` holds, and data is stable.

## Test plan
- Reset behaviour: assert RST for 2 cycles with all ENA = 1.
  - During reset: `in_enq__RDY` = 0 and `out_enq__ENA` = 0.
  - After release: the first RDY = 4'b1111, and no beat is emitted from pre-reset stimulus.
- Single requester: requester 2 enqs 0xA5 at cycle t with the sink ready.
  - Cycle t+1: `out_enq__ENA` = 1, `out_enq_v` = 0xA5, `out_src` = 2.
  - Cycle t+2: `in_enq__RDY[2]` = 1 again.
- Round-robin fairness: all 4 requesters enq continuously with payload = index, sink always ready, prio_fixed = 0.
  - `out_src` sequence starts 0,1,2,3,0,1,…
  - Over 400 beats: exactly 100 beats per source, and no gaps after the first beat.
- Backpressure: fill slots 1 and 3, hold `out_enq__RDY` = 0 for 10 cycles.
  - During the hold: ENA = 0, `in_enq__RDY` = 4'b0101.
  - After release: beats 1 then 3 on consecutive cycles.
- Fixed priority: fill all slots, set prio_fixed = 1.
  - Output order is 0,1,2,3. Refilling slot 0 every other cycle starves slot 3 until slot 0 stops.
  - Switching to prio_fixed = 0 then resumes from `last`+1.
- Reset mid-stream: assert RST while 3 slots are full and a beat is being presented.
  - No further beats appear.
  - Post-reset round-robin starts at requester 0.

Source files
------------

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter that serializes N single-entry requester slots into one pipe sink.
// Each beat is tagged with its source index. Fixed-priority mode can be selected per cycle.
module pipe_rr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 144,
  parameter int IDXW  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         in_enq__ENA,
  input  logic [N*WIDTH-1:0]   in_enq_v,
  output logic [N-1:0]         in_enq__RDY,
  input  logic                 prio_fixed,
  output logic                 out_enq__ENA,
  output logic [WIDTH-1:0]     out_enq_v,
  output logic [IDXW-1:0]      out_src,
  input  logic                 out_enq__RDY
);

  logic [N-1:0]     full_q, full_d;
  logic [WIDTH-1:0] data_q [N];
  logic [WIDTH-1:0] data_d [N];
  logic [IDXW-1:0]  last_q, last_d;

  logic             any_full;
  logic [IDXW-1:0]  winner;
  logic [WIDTH-1:0] winner_data;
  logic             drain;

  assign in_enq__RDY = ~full_q & {N{~RST}};

  // Rank candidates by distance past the last winner (round-robin) or by raw index (fixed).
  always_comb begin
    int best_key;
    int key;
    any_full    = 1'b0;
    winner      = '0;
    winner_data = '0;
    best_key    = N;
    key         = 0;
    for (int i = 0; i < N; i++) begin
      key = i - int'(last_q) - 1;
      if (key < 0) key = key + N;
      if (prio_fixed) key = i;
      if (full_q[i] && (key < best_key)) begin
        best_key    = key;
        any_full    = 1'b1;
        winner      = IDXW'(i);
        winner_data = data_q[i];
      end
    end
  end

  assign drain        = any_full && out_enq__RDY && !RST;
  assign out_enq__ENA = drain;
  assign out_enq_v    = drain ? winner_data : '0;
  assign out_src      = drain ? winner : '0;

  // A slot can never capture and drain on the same edge: RDY is low whenever it is full.
  always_comb begin
    full_d = full_q;
    last_d = last_q;
    data_d = data_q;
    for (int i = 0; i < N; i++) begin
      if (in_enq__ENA[i] && in_enq__RDY[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = in_enq_v[i*WIDTH +: WIDTH];
      end
      if (drain && (winner == IDXW'(i))) begin
        full_d[i] = 1'b0;
      end
    end
    if (drain) last_d = winner;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      full_q <= '0;
      last_q <= IDXW'(N - 1);
    end else begin
      full_q <= full_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge CLK) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed self-checking bench for pipe_rr_arbiter (N=4, WIDTH=144).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_pipe_rr_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 144;
  localparam int IDXW  = 2;

  logic               CLK;
  logic               RST;
  logic [N-1:0]       ena;
  logic [N*WIDTH-1:0] vbus;
  logic [N-1:0]       rdy;
  logic               fixed;
  logic               oena;
  logic [WIDTH-1:0]   ov;
  logic [IDXW-1:0]    osrc;
  logic               sink_rdy;

  int errors;
  int checks;
  int cnt [N];

  pipe_rr_arbiter #(.N(N), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_enq__ENA  (ena),
    .in_enq_v     (vbus),
    .in_enq__RDY  (rdy),
    .prio_fixed   (fixed),
    .out_enq__ENA (oena),
    .out_enq_v    (ov),
    .out_src      (osrc),
    .out_enq__RDY (sink_rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole output beat: {ENA, src, payload}.
  task checkBeat(input string tag, input logic e, input logic [1:0] s, input logic [7:0] v);
    checkOutput(tag, 160'({oena, osrc, ov}), 160'({e, s, 144'(v)}));
  endtask

  task applyStimulus(input logic r, input logic [N-1:0] e, input logic s, input logic f);
    RST      = r;
    ena      = e;
    sink_rdy = s;
    fixed    = f;
    #1;
  endtask

  task stepClock;
    @(posedge CLK);
    #1;
  endtask

  task setPayload(input int i, input logic [7:0] val);
    vbus[i*WIDTH +: WIDTH] = 144'(val);
  endtask

  task applyReset;
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    vbus   = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;

    // Reset with every requester pushing.
    for (int i = 0; i < N; i++) setPayload(i, 8'hEE);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      checkOutput("rst_rdy", 160'(rdy), 160'(4'b0000));
      checkBeat("rst_beat", 1'b0, 2'd0, 8'h00);
      stepClock();
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("post_rst_rdy", 160'(rdy), 160'(4'b1111));
    checkBeat("post_rst_beat", 1'b0, 2'd0, 8'h00);
    stepClock();
    checkBeat("post_rst_beat2", 1'b0, 2'd0, 8'h00);

    // Single requester 2.
    setPayload(2, 8'hA5);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkBeat("single_beat", 1'b1, 2'd2, 8'hA5);
    checkOutput("single_rdy_busy", 160'(rdy), 160'(4'b1011));
    stepClock();
    checkOutput("single_rdy_back", 160'(rdy), 160'(4'b1111));
    checkBeat("single_idle", 1'b0, 2'd0, 8'h00);

    // Round-robin fairness, all requesters pushing continuously.
    applyReset();
    for (int i = 0; i < N; i++) setPayload(i, 8'(i));
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
    checkBeat("rr_first_idle", 1'b0, 2'd0, 8'h00);
    stepClock();
    for (int b = 0; b < 400; b++) begin
      checkBeat("rr_beat", 1'b1, 2'(b % 4), 8'(b % 4));
      if (oena) cnt[osrc]++;
      stepClock();
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) checkOutput("rr_count", 160'(cnt[i]), 160'(100));

    // Backpressure on slots 1 and 3.
    applyReset();
    setPayload(1, 8'h11);
    setPayload(3, 8'h33);
    applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      checkBeat("bp_hold_beat", 1'b0, 2'd0, 8'h00);
      checkOutput("bp_hold_rdy", 160'(rdy), 160'(4'b0101));
      stepClock();
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkBeat("bp_rel_1", 1'b1, 2'd1, 8'h11);
    stepClock();
    checkBeat("bp_rel_3", 1'b1, 2'd3, 8'h33);
    stepClock();
    checkBeat("bp_rel_idle", 1'b0, 2'd0, 8'h00);

    // Fixed priority: order, starvation of high slots, then return to round-robin.
    applyReset();
    for (int i = 0; i < N; i++) setPayload(i, 8'(8'h40 + i));
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkBeat("fix_order", 1'b1, 2'(k), 8'(8'h40 + k));
      stepClock();
    end
    checkBeat("fix_idle", 1'b0, 2'd0, 8'h00);
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 4'b0011, 1'b1, 1'b1);
    for (int g = 0; g < 10; g++) begin
      checkBeat("fix_starve", 1'b1, 2'(g % 2), 8'(8'h40 + (g % 2)));
      stepClock();
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkBeat("fix_to_rr_2", 1'b1, 2'd2, 8'h42);
    stepClock();
    checkBeat("fix_to_rr_3", 1'b1, 2'd3, 8'h43);
    stepClock();
    checkBeat("fix_to_rr_0", 1'b1, 2'd0, 8'h40);
    stepClock();
    checkBeat("fix_to_rr_idle", 1'b0, 2'd0, 8'h00);

    // Reset in the middle of a stream.
    applyReset();
    for (int i = 0; i < N; i++) setPayload(i, 8'(8'h70 + i));
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkBeat("mid_beat0", 1'b1, 2'd0, 8'h70);
    stepClock();
    checkBeat("mid_beat1", 1'b1, 2'd1, 8'h71);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    checkBeat("mid_rst_beat", 1'b0, 2'd0, 8'h00);
    checkOutput("mid_rst_rdy", 160'(rdy), 160'(4'b0000));
    stepClock();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkBeat("mid_after_beat", 1'b0, 2'd0, 8'h00);
      checkOutput("mid_after_rdy", 160'(rdy), 160'(4'b1111));
      stepClock();
    end
    setPayload(0, 8'h80);
    setPayload(2, 8'h82);
    applyStimulus(1'b0, 4'b0101, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkBeat("mid_rr_0", 1'b1, 2'd0, 8'h80);
    stepClock();
    checkBeat("mid_rr_2", 1'b1, 2'd2, 8'h82);
    stepClock();
    checkBeat("mid_rr_idle", 1'b0, 2'd0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
